// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/LS arbiter for one shared single-port memory (optional: ARB_STARVE_GUARD_EN)
module unified_mem_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_valid,
    output logic        o_stall_if,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [3:0]  i_ls_be,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_valid,
    output logic        o_stall_ls,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, DONE} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    // Both counters are 4 bits wide, so both parameters must fit 1..15.
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_param_check
        $error("unified_mem_arbiter: MEM_LATENCY and STARVE_LIMIT must be in 1..15");
    end

    state_t     state;
    logic [3:0] lat_cnt;
    logic [3:0] lat_nxt;
    logic       grant_if_forced;

    assign lat_nxt    = lat_cnt + 4'd1;
    assign o_stall_if = i_if_req & ~o_if_valid;
    assign o_stall_ls = i_ls_req & ~o_ls_valid;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign grant_if_forced = i_if_req && (starve_cnt == LIMIT);

    // Count LS grants that overtake a waiting fetch; any fetch grant clears the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (i_ls_req && !grant_if_forced) begin
                if (i_if_req && starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else if (i_if_req) begin
                starve_cnt <= '0;
            end
        end
    end
`else
    assign grant_if_forced = 1'b0;
`endif

    // Grant / fixed-latency wait / completion bubble sequencer with registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            o_if_rdata  <= '0;
            o_if_valid  <= 1'b0;
            o_ls_rdata  <= '0;
            o_ls_valid  <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_mem_en   <= 1'b0;
            o_if_valid <= 1'b0;
            o_ls_valid <= 1'b0;
            case (state)
                IDLE: begin
                    lat_cnt <= '0;
                    if (i_ls_req && !grant_if_forced) begin
                        o_mem_en    <= 1'b1;
                        o_mem_we    <= i_ls_we;
                        o_mem_be    <= i_ls_we ? i_ls_be : 4'hF;
                        o_mem_addr  <= i_ls_addr;
                        o_mem_wdata <= i_ls_wdata;
                        state       <= BUSY_LS;
                    end else if (i_if_req) begin
                        o_mem_en   <= 1'b1;
                        o_mem_we   <= 1'b0;
                        o_mem_be   <= 4'hF;
                        o_mem_addr <= i_if_addr;
                        state      <= BUSY_IF;
                    end
                end
                BUSY_IF: begin
                    lat_cnt <= lat_nxt;
                    if (lat_nxt == LAT) begin
                        o_if_rdata <= i_mem_rdata;
                        o_if_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                BUSY_LS: begin
                    lat_cnt <= lat_nxt;
                    if (lat_nxt == LAT) begin
                        o_ls_rdata <= i_mem_rdata;
                        o_ls_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
